// File: rtl/aes_4to128.sv
`default_nettype none
// ============================================================================
//  Module      : aes_4to128
//  Description : Front-end loader for the AES core. Deserialises a 4-bit
//                plaintext stream and a 4-bit key stream into one 128-bit
//                plaintext block and one 128-bit key, then strobes ld for
//                one cycle so the downstream cipher can latch them.
//  Ports       : clk      - clock, all state changes on rising edge
//                rst      - asynchronous active-high reset
//                en       - start request, sampled only while idle
//                block    - plaintext nibble, sampled every load cycle
//                key      - key nibble, sampled every load cycle
//                text_in  - assembled plaintext block (registered)
//                key_in   - assembled key (registered)
//                ld       - one-cycle strobe: text_in/key_in are new
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_4to128 #(
   parameter int NIB_W  = 4,
   parameter int WORD_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NIB_W-1:0]  block,
   input  logic [NIB_W-1:0]  key,
   output logic [WORD_W-1:0] text_in,
   output logic [WORD_W-1:0] key_in,
   output logic              ld
);

   localparam int NIBBLES = WORD_W / NIB_W;
   localparam int CNT_W   = $clog2(NIBBLES);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // state and count keep plain names so they can be probed hierarchically.
   state_t            state;
   state_t            state_d;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_d;
   logic [WORD_W-1:0] sh_t_q;
   logic [WORD_W-1:0] sh_t_d;
   logic [WORD_W-1:0] sh_k_q;
   logic [WORD_W-1:0] sh_k_d;
   logic [WORD_W-1:0] text_in_d;
   logic [WORD_W-1:0] key_in_d;
   logic              ld_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         sh_t_q  <= '0;
         sh_k_q  <= '0;
         text_in <= '0;
         key_in  <= '0;
         ld      <= 1'b0;
      end else begin
         state   <= state_d;
         count   <= count_d;
         sh_t_q  <= sh_t_d;
         sh_k_q  <= sh_k_d;
         text_in <= text_in_d;
         key_in  <= key_in_d;
         ld      <= ld_d;
      end
   end

   always_comb begin
      state_d   = state;
      count_d   = count;
      sh_t_d    = sh_t_q;
      sh_k_d    = sh_k_q;
      text_in_d = text_in;
      key_in_d  = key_in;
      ld_d      = 1'b0;

      case (state)
         IDLE: begin
            // The accepting edge captures no nibble; capture starts next edge.
            if (en) begin
               state_d = LOAD;
               count_d = '0;
            end
         end
         LOAD: begin
            // MSB-first: the first nibble migrates to the top of the word.
            sh_t_d = {sh_t_q[WORD_W-NIB_W-1:0], block};
            sh_k_d = {sh_k_q[WORD_W-NIB_W-1:0], key};
            if (count == c_LAST) begin
               // Publish the words including the nibble captured this edge.
               text_in_d = sh_t_d;
               key_in_d  = sh_k_d;
               ld_d      = 1'b1;
               count_d   = '0;
               state_d   = DONE;
            end else begin
               count_d = count + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_4to128.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_4to128
//  Description : Self-checking bench for aes_4to128. Table of nibble streams
//                with expected words, randomized loads checked against an
//                assembling model, plus reset, idle-hold and back-to-back
//                cadence sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_4to128;

   logic         clk;
   logic         rst;
   logic         en;
   logic [3:0]   block;
   logic [3:0]   key;
   logic [127:0] text_in;
   logic [127:0] key_in;
   logic         ld;

   int vectors;
   int miscompares;

   aes_4to128 dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .block   (block),
      .key     (key),
      .text_in (text_in),
      .key_in  (key_in),
      .ld      (ld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0][3:0] bn;    // bn[i] = i-th plaintext nibble presented
      logic [31:0][3:0] kn;    // kn[i] = i-th key nibble presented
      logic [127:0]     exp_t;
      logic [127:0]     exp_k;
   } vec_t;

   localparam int NVEC = 7;
   vec_t vecs[NVEC];

   // Reference: nibble i of the stream lands in word bits [127-4i -: 4].
   function automatic logic [127:0] assemble(input logic [31:0][3:0] s);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < 32; i++) w[127-4*i -: 4] = s[i];
      return w;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Starts at a negedge with the DUT idle; ends at the negedge after DONE.
   task automatic run_load(input vec_t v, input string nm);
      logic early_ld;
      early_ld = 1'b0;
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      chk({nm, " state after en"}, 128'(dut.state), 128'd1);
      chk({nm, " count after en"}, 128'(dut.count), 128'd0);
      for (int i = 0; i < 32; i++) begin
         block = v.bn[i];
         key   = v.kn[i];
         @(negedge clk);
         if (i < 31 && ld !== 1'b0) early_ld = 1'b1;
      end
      chk({nm, " ld during load"}, 128'(early_ld), 128'd0);
      chk({nm, " ld strobe"}, 128'(ld), 128'd1);
      chk({nm, " text_in"}, text_in, v.exp_t);
      chk({nm, " key_in"}, key_in, v.exp_k);
      chk({nm, " state done"}, 128'(dut.state), 128'd2);
      block = 4'($urandom);
      key   = 4'($urandom);
      @(negedge clk);
      chk({nm, " ld cleared"}, 128'(ld), 128'd0);
      chk({nm, " state idle"}, 128'(dut.state), 128'd0);
      chk({nm, " text held"}, text_in, v.exp_t);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t         v;
      logic [127:0] exp_t;
      logic [127:0] exp_k;
      logic [127:0] last_t;
      logic [127:0] last_k;
      logic         bad;

      vectors     = 0;
      miscompares = 0;
      rst   = 1'b1;
      en    = 1'b0;
      block = 4'h0;
      key   = 4'h0;

      // ---------------- table ----------------
      for (int i = 0; i < 32; i++) begin
         vecs[0].bn[i] = 4'h5;
         vecs[0].kn[i] = 4'hA;
         vecs[1].bn[i] = 4'(i % 16);
         vecs[1].kn[i] = 4'(15 - (i % 16));
         vecs[2].bn[i] = (i < 10) ? 4'h5 : 4'hA;
         vecs[2].kn[i] = 4'h0;
      end
      vecs[0].exp_t = {32{4'h5}};
      vecs[0].exp_k = {32{4'hA}};
      vecs[1].exp_t = 128'h0123456789ABCDEF0123456789ABCDEF;
      vecs[1].exp_k = 128'hFEDCBA9876543210FEDCBA9876543210;
      vecs[2].exp_t = 128'h5555555555AAAAAAAAAAAAAAAAAAAAAA;
      vecs[2].exp_k = 128'h0;
      for (int n = 3; n < NVEC; n++) begin
         for (int i = 0; i < 32; i++) begin
            vecs[n].bn[i] = 4'($urandom_range(0, 15));
            vecs[n].kn[i] = 4'($urandom_range(0, 15));
         end
         vecs[n].exp_t = assemble(vecs[n].bn);
         vecs[n].exp_k = assemble(vecs[n].kn);
      end

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      chk("reset state", 128'(dut.state), 128'd0);
      chk("reset count", 128'(dut.count), 128'd0);
      chk("reset text_in", text_in, 128'd0);
      chk("reset key_in", key_in, 128'd0);
      chk("reset ld", 128'(ld), 128'd0);
      rst = 1'b0;
      @(negedge clk);

      // ---------------- table loads ----------------
      for (int n = 0; n < NVEC; n++) begin
         run_load(vecs[n], $sformatf("vec%0d", n));
         repeat (2) @(negedge clk);
      end

      // ---------------- inputs change while idle ----------------
      last_t = vecs[NVEC-1].exp_t;
      last_k = vecs[NVEC-1].exp_k;
      bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         block = 4'($urandom);
         key   = 4'($urandom);
         @(negedge clk);
         if (ld !== 1'b0 || text_in !== last_t || key_in !== last_k) bad = 1'b1;
      end
      chk("idle hold", 128'(bad), 128'd0);

      // ---------------- reset mid-load ----------------
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 15; i++) begin
         block = 4'($urandom);
         key   = 4'($urandom);
         @(negedge clk);
      end
      chk("midload count", 128'(dut.count), 128'd15);
      #2 rst = 1'b1;
      #1;
      chk("async rst text_in", text_in, 128'd0);
      chk("async rst key_in", key_in, 128'd0);
      chk("async rst state", 128'(dut.state), 128'd0);
      chk("async rst count", 128'(dut.count), 128'd0);
      chk("async rst ld", 128'(ld), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ld !== 1'b0 || dut.state !== 2'd0) bad = 1'b1;
      end
      chk("no ld after rst", 128'(bad), 128'd0);
      run_load(vecs[1], "post-rst");
      @(negedge clk);

      // ---------------- back-to-back with en high/toggling ----------------
      // Edge e: remainder r = e % 34. r==0 samples en in IDLE, r in 1..32
      // capture nibbles, r==32 publishes, r==33 returns to IDLE.
      exp_t = '0;
      exp_k = '0;
      for (int e = 0; e < 3 * 34; e++) begin
         int r;
         logic [3:0] bt;
         logic [3:0] kt;
         r  = e % 34;
         en = (r == 0) ? 1'b1 : 1'($urandom);
         bt = 4'($urandom);
         kt = 4'($urandom);
         block = bt;
         key   = kt;
         if (r >= 1 && r <= 32) begin
            exp_t[127-4*(r-1) -: 4] = bt;
            exp_k[127-4*(r-1) -: 4] = kt;
         end
         @(negedge clk);
         chk($sformatf("b2b ld e%0d", e), 128'(ld), (r == 32) ? 128'd1 : 128'd0);
         chk($sformatf("b2b state e%0d", e), 128'(dut.state),
             (r == 32) ? 128'd2 : (r == 33) ? 128'd0 : 128'd1);
         chk($sformatf("b2b count e%0d", e), 128'(dut.count),
             (r <= 31) ? 128'(r) : 128'd0);
         if (r == 32) begin
            chk($sformatf("b2b text e%0d", e), text_in, exp_t);
            chk($sformatf("b2b key e%0d", e), key_in, exp_k);
         end
      end
      en = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
